ram_burst_tracker: RTL

Converts the filtered, per-clock-edge RAM bus samples from the sampler into a stream of trace packets: one ADDR packet per address latch, then one READ or WRITE packet per data beat, each carrying the computed word address. It tracks synchronous-burst latency and burst length, queues packets in a small first-word-fall-through FIFO, and hands them to the downstream trace/USB packer over a valid/ready handshake. Dropped packets are reported when the FIFO overflows.

---
 rtl/ram_trace_pkg.sv | 36 +++
 rtl/ram_trace_fifo.sv | 61 ++++++
 rtl/ram_burst_tracker.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ram_trace_pkg.sv
// Shared constants and packet layout for the RAM bus trace path.
// Packet = {kind, addr, data, ublb}, 43 bits.
package ram_trace_pkg;

    localparam int RAM_AW = 23;
    localparam int RAM_DW = 16;
    localparam int PKT_W  = 2 + RAM_AW + RAM_DW + 2;

    localparam logic [1:0] PKT_ADDR  = 2'd0;
    localparam logic [1:0] PKT_READ  = 2'd1;
    localparam logic [1:0] PKT_WRITE = 2'd2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    typedef struct packed {
        logic [1:0]        kind;
        logic [RAM_AW-1:0] addr;
        logic [RAM_DW-1:0] data;
        logic [1:0]        ublb;
    } pkt_t;

    function automatic pkt_t make_pkt(input logic [1:0]        kind,
                                      input logic [RAM_AW-1:0] addr,
                                      input logic [RAM_DW-1:0] data,
                                      input logic [1:0]        ublb);
        pkt_t p;
        p.kind = kind;
        p.addr = addr;
        p.data = data;
        p.ublb = ublb;
        return p;
    endfunction

endpackage

// File: rtl/ram_trace_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is presented combinationally
// and reads as zero while empty. A push into a full FIFO is taken if a pop coincides.
module ram_trace_fifo #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_push_accept
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_pop;
    logic             w_push;

    assign o_empty       = (r_count == '0);
    assign o_full        = (r_count == (AW+1)'(DEPTH));
    assign w_pop         = i_pop & ~o_empty;
    assign o_push_accept = ~o_full | w_pop;
    assign w_push        = i_push & o_push_accept;
    assign o_data        = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage carries no reset; the head is masked while empty instead.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_burst_tracker.sv
// Turns strobed RAM bus samples into ADDR/READ/WRITE trace packets via a FWFT FIFO.
// Build option: RAM_BURST_DROP_COUNT_EN adds a saturating 16-bit dropped-packet counter.
module ram_burst_tracker
    import ram_trace_pkg::*;
#(
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic [RAM_AW-1:0] filter_a,
    input  logic [RAM_DW-1:0] filter_d,
    input  logic [1:0]        filter_ublb,
    input  logic              filter_read,
    input  logic              filter_write,
    input  logic              filter_addr_latch,
    input  logic              filter_strobe,
    output logic              pkt_valid,
    input  logic              pkt_ready,
    output logic [1:0]        pkt_type,
    output logic [RAM_AW-1:0] pkt_addr,
    output logic [RAM_DW-1:0] pkt_data,
    output logic [1:0]        pkt_ublb,
    output logic              busy,
    output logic              overflow,
    input  logic              overflow_clear,
    output logic [15:0]       drop_count,
    output logic [1:0]        dbg_state
);

    // Handshake: a packet moves downstream on any cycle where pkt_valid && pkt_ready;
    // the head fields hold steady while pkt_valid && !pkt_ready.

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [1:0]        r_state;
    logic [3:0]        r_wait_cnt;
    logic [RAM_AW-1:0] r_base;
    logic [RAM_AW-1:0] r_index;
    logic              r_overflow;

    logic              w_latch;
    logic              w_beat;
    logic [RAM_AW-1:0] w_beat_addr;
    logic              w_push;
    pkt_t              w_push_pkt;
    pkt_t              w_head_pkt;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_push_accept;
    logic              w_drop;

    assign w_latch     = filter_strobe & filter_addr_latch;
    assign w_beat      = filter_strobe & ~filter_addr_latch & (r_state == ST_BURST)
                       & (filter_read | filter_write);
    assign w_beat_addr = r_base + r_index;

    always_comb begin
        w_push     = 1'b0;
        w_push_pkt = '0;
        if (w_latch) begin
            w_push     = 1'b1;
            w_push_pkt = make_pkt(PKT_ADDR, filter_a, '0, filter_ublb);
        end else if (w_beat) begin
            w_push     = 1'b1;
            w_push_pkt = make_pkt(filter_write ? PKT_WRITE : PKT_READ,
                                  w_beat_addr, filter_d, filter_ublb);
        end
    end

    // A latch restarts the sequence from any state, including mid-burst.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_base     <= '0;
            r_index    <= '0;
        end else if (filter_strobe) begin
            if (filter_addr_latch) begin
                r_base  <= filter_a;
                r_index <= '0;
                if (LATENCY == 1) begin
                    r_state <= ST_BURST;
                end else begin
                    r_wait_cnt <= LAT_M1;
                    r_state    <= ST_WAIT;
                end
            end else begin
                case (r_state)
                    ST_WAIT: begin
                        if (!filter_read && !filter_write) begin
                            r_state <= ST_IDLE;
                        end else if (r_wait_cnt == 4'd1) begin
                            r_state <= ST_BURST;
                        end else begin
                            r_wait_cnt <= r_wait_cnt - 4'd1;
                        end
                    end
                    ST_BURST: begin
                        if (filter_read || filter_write) begin
                            r_index <= r_index + RAM_AW'(1);
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    ram_trace_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk         (mclk),
        .i_reset       (reset),
        .i_push        (w_push),
        .i_data        (w_push_pkt),
        .i_pop         (w_pop),
        .o_data        (w_head_pkt),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_push_accept (w_push_accept)
    );

    assign pkt_valid = ~w_empty;
    assign w_pop     = pkt_valid & pkt_ready;
    assign w_drop    = w_push & ~w_push_accept;
    assign pkt_type  = w_head_pkt.kind;
    assign pkt_addr  = w_head_pkt.addr;
    assign pkt_data  = w_head_pkt.data;
    assign pkt_ublb  = w_head_pkt.ublb;
    assign busy      = (r_state != ST_IDLE);
    assign dbg_state = r_state;
    assign overflow  = r_overflow;

    // A drop outranks a simultaneous clear so the loss is never hidden.
    always_ff @(posedge mclk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflow_clear) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge mclk) begin
        if (!reset) begin
            assert (!(w_drop && !w_full));
        end
    end

`ifdef RAM_BURST_DROP_COUNT_EN
    logic [15:0] r_drop_count;

    always_ff @(posedge mclk) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_drop) begin
            if (overflow_clear) begin
                r_drop_count <= 16'd1;
            end else if (r_drop_count != 16'hFFFF) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end else if (overflow_clear) begin
            r_drop_count <= '0;
        end
    end

    assign drop_count = r_drop_count;
`else
    assign drop_count = '0;
`endif

endmodule
